exe_ctrl: RTL and testbench

Sequencer for the execute stage. It accepts one decoded instruction at a time from ID over a valid/ready handshake and holds operands, ALU opcode and operand-select stable on the EXE inputs for a programmable number of cycles. It then captures the 33-bit EXE result, updates the CPSR NZCV flags, and presents the 32-bit result to register writeback over a second valid/ready handshake. It owns the architectural CPSR flag register.

---
 rtl/exe_pkg.sv | 25 ++
 rtl/exe_flag_gen.sv | 33 +++
 rtl/exe_ctrl.sv | 115 +++++++++++
 tb/tb_exe_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute-stage sequencer.
// Opcodes, CPSR flag positions and controller states.
package exe_pkg;

  localparam logic [2:0] OC_ADD = 3'd0;
  localparam logic [2:0] OC_SUB = 3'd1;
  localparam logic [2:0] OC_AND = 3'd2;
  localparam logic [2:0] OC_OR  = 3'd3;
  localparam logic [2:0] OC_XOR = 3'd4;
  localparam logic [2:0] OC_NOT = 3'd5;
  localparam logic [2:0] OC_LSL = 3'd6;
  localparam logic [2:0] OC_LSR = 3'd7;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

endpackage

// File: rtl/exe_flag_gen.sv
// Combinational NZCV generation for the execute stage.
// Only ADD/SUB produce C and V; other opcodes carry them over.
module exe_flag_gen
  import exe_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [32:0] r,
  input  logic [2:0]  alu_oc,
  input  logic [31:0] cpsr_old,
  output logic [31:0] cpsr_new
);

  always_comb begin
    cpsr_new        = '0;
    cpsr_new[N_BIT] = r[31];
    cpsr_new[Z_BIT] = (r[31:0] == 32'd0);
    cpsr_new[C_BIT] = cpsr_old[C_BIT];
    cpsr_new[V_BIT] = cpsr_old[V_BIT];
    unique case (1'b1)
      (alu_oc == OC_ADD): begin
        cpsr_new[C_BIT] = r[32];
        cpsr_new[V_BIT] = (a[31] == b[31]) & (r[31] != a[31]);
      end
      (alu_oc == OC_SUB): begin
        cpsr_new[C_BIT] = r[32];
        cpsr_new[V_BIT] = (a[31] != b[31]) & (r[31] != a[31]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exe_ctrl.sv
// Execute-stage sequencer: holds operands on EXE, samples the
// result, updates CPSR and hands the result to writeback.
module exe_ctrl
  import exe_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int REG_ADDR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [2:0]            id_alu_oc,
  input  logic                  id_ir_op,
  input  logic [31:0]           id_value1,
  input  logic [31:0]           id_value2,
  input  logic [31:0]           id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wb_en,
  input  logic                  id_set_flags,
  output logic [31:0]           exe_value1,
  output logic [31:0]           exe_value2,
  output logic [31:0]           exe_imm,
  output logic [2:0]            exe_alu_oc,
  output logic                  exe_ir_op,
  input  logic [32:0]           exe_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  output logic [31:0]           cpsr,
  output logic                  busy
);

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic                    wb_en_q;
  logic                    set_flags_q;
  logic                    accept;
  logic                    sample;
  logic [31:0]             b_sel;
  logic [31:0]             cpsr_nxt;

  assign id_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign wb_valid = (state == WB);
  assign accept   = id_valid & id_ready;
  assign sample   = (state == EXEC) && (cnt == 4'd0);
  assign b_sel    = exe_ir_op ? exe_value2 : exe_imm;

  exe_flag_gen u_flag (
    .a        (exe_value1),
    .b        (b_sel),
    .r        (exe_result),
    .alu_oc   (exe_alu_oc),
    .cpsr_old (cpsr),
    .cpsr_new (cpsr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (sample) state_nxt = wb_en_q ? WB : IDLE;
      WB:      if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      exe_value1  <= '0;
      exe_value2  <= '0;
      exe_imm     <= '0;
      exe_alu_oc  <= '0;
      exe_ir_op   <= 1'b0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      set_flags_q <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      cpsr        <= '0;
    end else begin
      if (accept) begin
        cnt         <= CNT_INIT;
        exe_value1  <= id_value1;
        exe_value2  <= id_value2;
        exe_imm     <= id_imm;
        exe_alu_oc  <= id_alu_oc;
        exe_ir_op   <= id_ir_op;
        rd_q        <= id_rd;
        wb_en_q     <= id_wb_en;
        set_flags_q <= id_set_flags;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        wb_data <= exe_result[31:0];
        wb_rd   <= rd_q;
        if (set_flags_q) cpsr <= cpsr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_exe_ctrl.sv
// Bench for exe_ctrl: two instances (1 and 4 exec cycles),
// directed table, randomized ops against a flag model, reset abort.
module tb_exe_ctrl;

  logic                  clk;
  logic [1:0]            rst;
  logic [1:0]            id_valid, id_ready, id_ir_op, id_wb_en, id_set_flags;
  logic [1:0]            exe_ir_op, wb_valid, wb_ready, busy;
  logic [1:0][2:0]       id_alu_oc, exe_alu_oc, id_rd, wb_rd;
  logic [1:0][31:0]      id_value1, id_value2, id_imm;
  logic [1:0][31:0]      exe_value1, exe_value2, exe_imm, wb_data, cpsr;
  logic [1:0][32:0]      exe_result;
  logic [1:0][31:0]      m_cpsr;
  int                    checks;
  int                    fails;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  typedef struct {
    logic [2:0]  oc;
    logic        ir;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [2:0]  rd;
    logic        we;
    logic        sf;
    logic [32:0] res;
    logic [31:0] cpsr;
    int          stall;
  } vec_t;

  vec_t tbl [8];

  exe_ctrl #(.EXEC_CYCLES(1), .REG_ADDR_W(3)) u1 (
    .clk(clk), .rst(rst[0]),
    .id_valid(id_valid[0]), .id_ready(id_ready[0]),
    .id_alu_oc(id_alu_oc[0]), .id_ir_op(id_ir_op[0]),
    .id_value1(id_value1[0]), .id_value2(id_value2[0]),
    .id_imm(id_imm[0]), .id_rd(id_rd[0]),
    .id_wb_en(id_wb_en[0]), .id_set_flags(id_set_flags[0]),
    .exe_value1(exe_value1[0]), .exe_value2(exe_value2[0]),
    .exe_imm(exe_imm[0]), .exe_alu_oc(exe_alu_oc[0]),
    .exe_ir_op(exe_ir_op[0]), .exe_result(exe_result[0]),
    .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]),
    .wb_rd(wb_rd[0]), .wb_data(wb_data[0]),
    .cpsr(cpsr[0]), .busy(busy[0])
  );

  exe_ctrl #(.EXEC_CYCLES(4), .REG_ADDR_W(3)) u4 (
    .clk(clk), .rst(rst[1]),
    .id_valid(id_valid[1]), .id_ready(id_ready[1]),
    .id_alu_oc(id_alu_oc[1]), .id_ir_op(id_ir_op[1]),
    .id_value1(id_value1[1]), .id_value2(id_value2[1]),
    .id_imm(id_imm[1]), .id_rd(id_rd[1]),
    .id_wb_en(id_wb_en[1]), .id_set_flags(id_set_flags[1]),
    .exe_value1(exe_value1[1]), .exe_value2(exe_value2[1]),
    .exe_imm(exe_imm[1]), .exe_alu_oc(exe_alu_oc[1]),
    .exe_ir_op(exe_ir_op[1]), .exe_result(exe_result[1]),
    .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]),
    .wb_rd(wb_rd[1]), .wb_data(wb_data[1]),
    .cpsr(cpsr[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut=%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  // The bench plays the EXE unit: 33-bit result, carry = no borrow on SUB.
  function automatic logic [32:0] alu(input logic [2:0] oc,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic hi;
    hi = 1'($urandom);
    case (oc)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'd2:    return {hi, a & b};
      3'd3:    return {hi, a | b};
      3'd4:    return {hi, a ^ b};
      3'd5:    return {hi, ~a};
      3'd6:    return {hi, a << b[4:0]};
      default: return {hi, a >> b[4:0]};
    endcase
  endfunction

  function automatic logic [31:0] flags(input logic [2:0] oc,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [32:0] r,
                                        input logic [31:0] old);
    longint          sa, sb, s;
    longint unsigned ua, ub;
    logic            n, z, c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    n  = r[31];
    z  = (r[31:0] == 32'd0);
    c  = old[29];
    v  = old[28];
    if (oc == 3'd0) begin
      s = sa + sb;
      c = (ua + ub) > 64'hFFFF_FFFF;
      v = (s > SMAX) || (s < SMIN);
    end else if (oc == 3'd1) begin
      s = sa - sb;
      c = (ua >= ub);
      v = (s > SMAX) || (s < SMIN);
    end
    return {n, z, c, v, 28'd0};
  endfunction

  task automatic run_op(input int d, input logic [2:0] oc, input logic ir,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [2:0] rd,
                        input logic we, input logic sf,
                        input logic [32:0] res, input logic [31:0] ecpsr,
                        input int stall);
    int e;
    e = (d == 1) ? 4 : 1;
    chk("idle_ready", d, id_ready[d], 1);
    id_valid[d] = 1'b1;
    id_alu_oc[d] = oc;
    id_ir_op[d] = ir;
    id_value1[d] = v1;
    id_value2[d] = v2;
    id_imm[d] = imm;
    id_rd[d] = rd;
    id_wb_en[d] = we;
    id_set_flags[d] = sf;
    wb_ready[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= e; c++) begin
      id_valid[d] = 1'($urandom);
      id_value1[d] = $urandom;
      id_value2[d] = $urandom;
      id_imm[d] = $urandom;
      id_alu_oc[d] = 3'($urandom);
      id_ir_op[d] = 1'($urandom);
      id_wb_en[d] = 1'($urandom);
      id_set_flags[d] = 1'($urandom);
      chk("exec_ready", d, id_ready[d], 0);
      chk("exec_busy", d, busy[d], 1);
      chk("exec_wbv", d, wb_valid[d], 0);
      chk("exe_value1", d, exe_value1[d], v1);
      chk("exe_value2", d, exe_value2[d], v2);
      chk("exe_imm", d, exe_imm[d], imm);
      chk("exe_alu_oc", d, exe_alu_oc[d], oc);
      chk("exe_ir_op", d, exe_ir_op[d], ir);
      if (c == e) exe_result[d] = res;
      else        exe_result[d] = {1'($urandom), 32'($urandom)};
      @(posedge clk);
      @(negedge clk);
    end
    exe_result[d] = {1'($urandom), 32'($urandom)};
    if (we) begin
      for (int s = 0; s <= stall; s++) begin
        chk("wb_valid", d, wb_valid[d], 1);
        chk("wb_data", d, wb_data[d], res[31:0]);
        chk("wb_rd", d, wb_rd[d], rd);
        chk("wb_id_ready", d, id_ready[d], 0);
        chk("wb_cpsr", d, cpsr[d], ecpsr);
        id_valid[d] = 1'($urandom);
        wb_ready[d] = (s == stall);
        @(posedge clk);
        @(negedge clk);
      end
      wb_ready[d] = 1'b0;
    end
    id_valid[d] = 1'b0;
    chk("done_wbv", d, wb_valid[d], 0);
    chk("done_ready", d, id_ready[d], 1);
    chk("done_cpsr", d, cpsr[d], ecpsr);
  endtask

  task automatic rand_op(input int d);
    logic [2:0]  oc;
    logic        ir, we, sf;
    logic [31:0] v1, v2, imm, b;
    logic [32:0] r;
    oc  = 3'($urandom);
    ir  = 1'($urandom);
    we  = 1'($urandom);
    sf  = 1'($urandom);
    v1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    v2  = ($urandom_range(0, 3) == 0) ? v1 : $urandom;
    imm = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
    b   = ir ? v2 : imm;
    r   = alu(oc, v1, b);
    if (sf) m_cpsr[d] = flags(oc, v1, b, r, m_cpsr[d]);
    run_op(d, oc, ir, v1, v2, imm, 3'($urandom), we, sf, r, m_cpsr[d],
           $urandom_range(0, 3));
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 2'b11;
    id_valid = '0; id_ir_op = '0; id_wb_en = '0; id_set_flags = '0;
    wb_ready = '0; id_alu_oc = '0; id_rd = '0;
    id_value1 = '0; id_value2 = '0; id_imm = '0; exe_result = '0;
    m_cpsr = '0;

    tbl[0] = '{3'd0, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h0, 3'd1, 1'b1, 1'b1,
               33'h0_80000000, 32'h90000000, 0};
    tbl[1] = '{3'd1, 1'b0, 32'd5, 32'h0, 32'd5, 3'd2, 1'b0, 1'b1,
               33'h1_00000000, 32'h60000000, 0};
    tbl[2] = '{3'd2, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 3'd3, 1'b1,
               1'b1, 33'h0, 32'h60000000, 0};
    tbl[3] = '{3'd0, 1'b0, 32'd1, 32'h0, 32'd2, 3'd4, 1'b1, 1'b0,
               33'h3, 32'h60000000, 5};
    tbl[4] = '{3'd4, 1'b1, 32'h80000001, 32'h1, 32'h0, 3'd5, 1'b1, 1'b1,
               33'h0_80000000, 32'hA0000000, 1};
    tbl[5] = '{3'd1, 1'b1, 32'd3, 32'd5, 32'h0, 3'd6, 1'b1, 1'b1,
               33'h0_FFFFFFFE, 32'h80000000, 0};
    tbl[6] = '{3'd1, 1'b0, 32'h80000000, 32'h0, 32'd1, 3'd7, 1'b1, 1'b1,
               33'h1_7FFFFFFF, 32'h30000000, 2};
    tbl[7] = '{3'd6, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1,
               33'h1_00000000, 32'h70000000, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 2'b00;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, id_ready[d], 1);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_wbv", d, wb_valid[d], 0);
      chk("rst_cpsr", d, cpsr[d], 0);
      chk("rst_exe_v1", d, exe_value1[d], 0);
      chk("rst_exe_oc", d, exe_alu_oc[d], 0);
      chk("rst_wb_data", d, wb_data[d], 0);
      chk("rst_wb_rd", d, wb_rd[d], 0);
    end

    for (int i = 0; i < 8; i++)
      run_op(0, tbl[i].oc, tbl[i].ir, tbl[i].v1, tbl[i].v2, tbl[i].imm,
             tbl[i].rd, tbl[i].we, tbl[i].sf, tbl[i].res, tbl[i].cpsr,
             tbl[i].stall);
    m_cpsr[0] = tbl[7].cpsr;

    repeat (80) rand_op(0);
    repeat (40) rand_op(1);

    // Slow instance: directed ADD, then abort it mid-EXEC with reset.
    run_op(1, tbl[0].oc, tbl[0].ir, tbl[0].v1, tbl[0].v2, tbl[0].imm,
           tbl[0].rd, tbl[0].we, tbl[0].sf, tbl[0].res, tbl[0].cpsr, 0);
    id_valid[1] = 1'b1;
    id_alu_oc[1] = 3'd0;
    id_ir_op[1] = 1'b1;
    id_value1[1] = 32'h1234;
    id_value2[1] = 32'h1;
    id_wb_en[1] = 1'b1;
    id_set_flags[1] = 1'b1;
    exe_result[1] = 33'h1235;
    @(posedge clk);
    @(negedge clk);
    id_valid[1] = 1'b0;
    chk("abort_busy", 1, busy[1], 1);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    chk("abort_busy0", 1, busy[1], 0);
    chk("abort_ready", 1, id_ready[1], 1);
    chk("abort_cpsr", 1, cpsr[1], 0);
    chk("abort_exe_v1", 1, exe_value1[1], 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_wbv", 1, wb_valid[1], 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_cpsr_end", 1, cpsr[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
